// File: rtl/tile_lane_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_lane_renderer
// Purpose  : Tile-drawing engine for the VGA game display. Draw requests
//            (lane, row, mode, colour) are queued in a small FIFO and turned
//            into a stream of one pixel per cycle (x, y, colour, plot) for
//            vga_adapter. Modes: fill, erase, invert-fill, clear whole lane.
// Ports    : clock, reset (async, active-high)
//            req_valid/req_ready/req_lane/req_row/req_mode/req_colour - request
//            x[7:0], y[6:0], colour[2:0], plot - registered pixel stream
//            busy  - FIFO non-empty or engine active
//            done  - 1-cycle pulse after the final pixel of a request
//            err   - 1-cycle pulse when a popped request is rejected
// Config   : TILE_BORDER_EN - when defined, fill and invert-fill tiles get a
//            one-pixel frame drawn in BORDER_COLOUR.
// Revision : 1.0 - initial release
// ============================================================================
module tile_lane_renderer #(
  parameter int LANES = 4,
  parameter int TILE_W = 40,
  parameter int TILE_H = 30,
  parameter int SCREEN_H = 120,
  parameter int X0 = 0,
  parameter int REQ_DEPTH = 4,
  parameter logic [2:0] BORDER_COLOUR = 3'b111,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int ROWS = SCREEN_H / TILE_H,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [LW-1:0] req_lane,
  input  logic [RW-1:0] req_row,
  input  logic [1:0]    req_mode,
  input  logic [2:0]    req_colour,
  output logic [7:0]    x,
  output logic [6:0]    y,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int c_aw  = $clog2(REQ_DEPTH);
  localparam int c_cxw = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int c_cyw = (ROWS * TILE_H > 1) ? $clog2(ROWS * TILE_H) : 1;
  localparam int c_ew  = LW + RW + 5;
  localparam logic [c_cxw-1:0] c_cx_last      = c_cxw'(TILE_W - 1);
  localparam logic [c_cyw-1:0] c_cy_tile_last = c_cyw'(TILE_H - 1);
  localparam logic [c_cyw-1:0] c_cy_lane_last = c_cyw'(ROWS * TILE_H - 1);
  localparam logic [1:0] c_MODE_FILL  = 2'b00;
  localparam logic [1:0] c_MODE_ERASE = 2'b01;
  localparam logic [1:0] c_MODE_INV   = 2'b10;
  localparam logic [1:0] c_MODE_LANE  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [c_ew-1:0] r_mem [REQ_DEPTH];
  logic [c_aw:0]   r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   w_count;
  logic            w_full, w_empty, w_push, w_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == (c_aw + 1)'(REQ_DEPTH));
  assign w_empty   = (w_count == '0);
  // Held low during reset so no request is lost while the queue is flushed.
  assign req_ready = !w_full && !reset;
  assign w_push    = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= {req_lane, req_row, req_mode, req_colour};
  end

  logic [c_ew-1:0] w_head;
  logic [LW-1:0]   w_h_lane;
  logic [RW-1:0]   w_h_row;
  logic [1:0]      w_h_mode;
  logic [2:0]      w_h_colour;
  logic            w_h_ok;
  logic [7:0]      w_h_xb;
  logic [6:0]      w_h_yb;

  assign w_head     = r_mem[r_rd_ptr[c_aw-1:0]];
  assign w_h_lane   = w_head[c_ew-1 -: LW];
  assign w_h_row    = w_head[5 +: RW];
  assign w_h_mode   = w_head[4:3];
  assign w_h_colour = w_head[2:0];
  // Row is irrelevant for a whole-lane clear, so it is never a reason to reject.
  assign w_h_ok     = (int'(w_h_lane) < LANES) &&
                      ((w_h_mode == c_MODE_LANE) || (int'(w_h_row) < ROWS));
  assign w_h_xb     = 8'(X0 + int'(w_h_lane) * TILE_W);
  assign w_h_yb     = (w_h_mode == c_MODE_LANE) ? 7'd0 : 7'(int'(w_h_row) * TILE_H);

  // ---------------------------------------------------------------- engine
  state_t           r_state, w_state_nx;
  logic [7:0]       r_xb;
  logic [6:0]       r_yb;
  logic [1:0]       r_mode;
  logic [2:0]       r_req_colour;
  logic [c_cxw-1:0] r_cx, w_nx_cx;
  logic [c_cyw-1:0] r_cy, w_nx_cy;
  logic [7:0]       r_x;
  logic [6:0]       r_y;
  logic [2:0]       r_pix_colour;
  logic             r_plot, r_done, r_err;
  logic             w_plot_nx, w_done_nx, w_err_nx, w_latch, w_last_pix, w_edge;
  logic [7:0]       w_sel_xb, w_px_x;
  logic [6:0]       w_sel_yb, w_px_y;
  logic [1:0]       w_sel_mode;
  logic [2:0]       w_sel_colour, w_px_colour;

  assign w_pop = (r_state == S_LOAD);

  // The pixel registered at the next edge comes from the head entry while
  // loading, otherwise from the latched request.
  assign w_sel_xb     = (r_state == S_LOAD) ? w_h_xb     : r_xb;
  assign w_sel_yb     = (r_state == S_LOAD) ? w_h_yb     : r_yb;
  assign w_sel_mode   = (r_state == S_LOAD) ? w_h_mode   : r_mode;
  assign w_sel_colour = (r_state == S_LOAD) ? w_h_colour : r_req_colour;

  assign w_last_pix = (r_cx == c_cx_last) &&
                      (r_cy == ((r_mode == c_MODE_LANE) ? c_cy_lane_last : c_cy_tile_last));

  always_comb begin
    w_nx_cx = '0;
    w_nx_cy = '0;
    if (r_state == S_DRAW) begin
      if (r_cx == c_cx_last) begin
        w_nx_cy = r_cy + c_cyw'(1);
      end else begin
        w_nx_cx = r_cx + c_cxw'(1);
        w_nx_cy = r_cy;
      end
    end
  end

`ifdef TILE_BORDER_EN
  assign w_edge = (w_nx_cx == '0) || (w_nx_cx == c_cx_last) ||
                  (w_nx_cy == '0) || (w_nx_cy == c_cy_tile_last);
`else
  assign w_edge = 1'b0;
`endif

  always_comb begin
    w_px_colour = 3'b000;
    case (w_sel_mode)
      c_MODE_FILL:  w_px_colour = w_edge ? BORDER_COLOUR : w_sel_colour;
      c_MODE_ERASE: w_px_colour = 3'b000;
      c_MODE_INV:   w_px_colour = w_edge ? BORDER_COLOUR : ~w_sel_colour;
      default:      w_px_colour = 3'b000;
    endcase
  end

  assign w_px_x = w_sel_xb + 8'(w_nx_cx);
  assign w_px_y = w_sel_yb + 7'(w_nx_cy);

  always_comb begin
    w_state_nx = r_state;
    w_plot_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nx = S_LOAD;
      S_LOAD: begin
        if (w_h_ok) begin
          w_state_nx = S_DRAW;
          w_plot_nx  = 1'b1;
          w_latch    = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
          w_err_nx   = 1'b1;
        end
      end
      S_DRAW: begin
        if (w_last_pix) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else begin
          w_plot_nx  = 1'b1;
        end
      end
      S_DONE:  w_state_nx = w_empty ? S_IDLE : S_LOAD;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_state      <= S_IDLE;
      r_xb         <= '0;
      r_yb         <= '0;
      r_mode       <= '0;
      r_req_colour <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_pix_colour <= '0;
      r_plot       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
      r_state <= w_state_nx;
      r_plot  <= w_plot_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
      if (w_latch) begin
        r_xb         <= w_h_xb;
        r_yb         <= w_h_yb;
        r_mode       <= w_h_mode;
        r_req_colour <= w_h_colour;
      end
      if (w_plot_nx) begin
        r_cx         <= w_nx_cx;
        r_cy         <= w_nx_cy;
        r_x          <= w_px_x;
        r_y          <= w_px_y;
        r_pix_colour <= w_px_colour;
      end
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_pix_colour;
  assign plot   = r_plot;
  assign done   = r_done;
  assign err    = r_err;
  assign busy   = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tile_lane_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_lane_renderer
// Purpose  : Directed self-checking bench for tile_lane_renderer. A default
//            instance covers drawing, queueing, lane clear and reset abort; a
//            small 3-lane/3-row instance covers request rejection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_lane_renderer;

`ifdef TILE_BORDER_EN
  localparam bit c_BORD = 1'b1;
`else
  localparam bit c_BORD = 1'b0;
`endif
  localparam logic [2:0] c_BORDER = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic       req_valid = 1'b0, req_ready;
  logic [1:0] req_lane = '0, req_row = '0, req_mode = '0;
  logic [2:0] req_colour = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done, err;

  // small instance: LANES=3, 4x3 tiles, 3 rows, X0=10
  logic       s_req_valid = 1'b0, s_req_ready;
  logic [1:0] s_req_lane = '0, s_req_row = '0, s_req_mode = '0;
  logic [2:0] s_req_colour = '0;
  logic [7:0] s_x;
  logic [6:0] s_y;
  logic [2:0] s_colour;
  logic       s_plot, s_busy, s_done, s_err;

  int n_cmp = 0;
  int n_fail = 0;

  tile_lane_renderer dut (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_lane(req_lane), .req_row(req_row), .req_mode(req_mode), .req_colour(req_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done), .err(err)
  );

  tile_lane_renderer #(.LANES(3), .TILE_W(4), .TILE_H(3), .SCREEN_H(9), .X0(10)) dut_s (
    .clock(clk), .reset(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_lane(s_req_lane), .req_row(s_req_row), .req_mode(s_req_mode), .req_colour(s_req_colour),
    .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot), .busy(s_busy), .done(s_done), .err(s_err)
  );

  // Present a request and hold it until the accepting edge; returns 1ns after it.
  task automatic push(input bit sel, input int lane, input int row,
                      input logic [1:0] mode, input logic [2:0] col);
    int n = 0;
    if (sel) begin
      s_req_valid = 1'b1; s_req_lane = 2'(lane); s_req_row = 2'(row);
      s_req_mode = mode; s_req_colour = col;
    end else begin
      req_valid = 1'b1; req_lane = 2'(lane); req_row = 2'(row);
      req_mode = mode; req_colour = col;
    end
    while (!(sel ? s_req_ready : req_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 20000) begin
      n_fail++;
      $display("FAIL push_timeout actual ready=0 required ready=1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    s_req_valid = 1'b0;
  endtask

  // Observe one request's pixel stream until done (or budget): counts plots,
  // raster-order and colour deviations against the expected rectangle.
  task automatic collect(input bit sel, input int xb, input int yb, input int w, input int h,
                         input logic [2:0] fill, input bit bord, input int budget,
                         output int plots, output int bad_pos, output int bad_col,
                         output int dones, output int errs, output int first,
                         output logic [2:0] c00, output logic [2:0] c11);
    int ex, ey, cyc, ox, oy;
    bit fin;
    logic p, d, e;
    logic [2:0] oc, ec;
    plots = 0; bad_pos = 0; bad_col = 0; dones = 0; errs = 0; first = -1;
    c00 = 3'bxxx; c11 = 3'bxxx;
    ex = xb; ey = yb; cyc = 0; fin = 1'b0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      p  = sel ? s_plot : plot;
      d  = sel ? s_done : done;
      e  = sel ? s_err : err;
      ox = sel ? int'(s_x) : int'(x);
      oy = sel ? int'(s_y) : int'(y);
      oc = sel ? s_colour : colour;
      if (p) begin
        plots++;
        if (first < 0) first = cyc;
        if (ox != ex || oy != ey) bad_pos++;
        ec = (bord && (ex == xb || ex == xb + w - 1 || ey == yb || ey == yb + h - 1)) ? c_BORDER : fill;
        if (oc !== ec) bad_col++;
        if (ox == xb && oy == yb) c00 = oc;
        if (ox == xb + 1 && oy == yb + 1) c11 = oc;
        ex++;
        if (ex == xb + w) begin
          ex = xb;
          ey++;
        end
      end
      if (d) begin
        dones++;
        fin = 1'b1;
      end
      if (e) errs++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({x, y, colour, plot, busy, done, err} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs actual=%h required=0", {x, y, colour, plot, busy, done, err});
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready actual=%b required=0", req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset actual ready=%b busy=%b required ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_single_fill();
    int pl, bp, bc, dn, er, fp;
    logic [2:0] a, b;
    push(0, 1, 2, 2'b00, 3'b100);
    collect(0, 40, 60, 40, 30, 3'b100, c_BORD, 1300, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (pl != 1200) begin n_fail++; $display("FAIL fill_plots actual=%0d required=1200", pl); end
    n_cmp++;
    if (bp != 0) begin n_fail++; $display("FAIL fill_order actual=%0d bad required=0", bp); end
    n_cmp++;
    if (bc != 0) begin n_fail++; $display("FAIL fill_colour actual=%0d bad required=0", bc); end
    n_cmp++;
    if (fp != 3) begin n_fail++; $display("FAIL fill_latency actual=%0d required=3", fp); end
    n_cmp++;
    if (dn != 1 || er != 0) begin
      n_fail++; $display("FAIL fill_done actual done=%0d err=%0d required 1/0", dn, er);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL fill_idle actual busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lane [6] = '{0, 1, 2, 3, 0, 2};
    int row  [6] = '{0, 1, 2, 3, 3, 1};
    logic [1:0] md [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [2:0] cl [6] = '{3'b001, 3'b010, 3'b011, 3'b111, 3'b110, 3'b000};
    push(0, lane[0], row[0], md[0], cl[0]);
    fork
      begin
        for (int i = 1; i < 5; i++) push(0, lane[i], row[i], md[i], cl[i]);
        n_cmp++;
        if (req_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_full_ready actual=%b required=0", req_ready);
        end
        push(0, lane[5], row[5], md[5], cl[5]);
      end
      begin
        for (int j = 0; j < 6; j++) begin
          int pl, bp, bc, dn, er, fp;
          logic [2:0] a, b, fc;
          bit bd;
          fc = (md[j] == 2'b10) ? ~cl[j] : ((md[j] == 2'b01) ? 3'b000 : cl[j]);
          bd = c_BORD && (md[j] != 2'b01);
          collect(0, lane[j] * 40, row[j] * 30, 40, 30, fc, bd, 1300, pl, bp, bc, dn, er, fp, a, b);
          n_cmp++;
          if (pl != 1200 || bp != 0 || bc != 0 || dn != 1) begin
            n_fail++;
            $display("FAIL b2b_req%0d actual plots=%0d badpos=%0d badcol=%0d done=%0d required 1200/0/0/1",
                     j, pl, bp, bc, dn);
          end
          n_cmp++;
          if (fp != ((j == 0) ? 3 : 2)) begin
            n_fail++; $display("FAIL b2b_gap%0d actual=%0d required=%0d", j, fp, (j == 0) ? 3 : 2);
          end
        end
      end
    join
  endtask

  task automatic test_reject();
    int pl, bp, bc, dn, er, fp;
    logic [2:0] a, b;
    // lane out of range
    push(1, 3, 0, 2'b00, 3'b101);
    collect(1, 0, 0, 4, 3, 3'b101, 1'b0, 8, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (er != 1 || pl != 0 || dn != 0) begin
      n_fail++; $display("FAIL reject_lane actual err=%0d plots=%0d done=%0d required 1/0/0", er, pl, dn);
    end
    // row out of range
    push(1, 0, 3, 2'b10, 3'b101);
    collect(1, 0, 0, 4, 3, 3'b101, 1'b0, 8, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (er != 1 || pl != 0 || dn != 0) begin
      n_fail++; $display("FAIL reject_row actual err=%0d plots=%0d done=%0d required 1/0/0", er, pl, dn);
    end
    // same row but lane clear: row ignored, accepted
    push(1, 2, 3, 2'b11, 3'b101);
    collect(1, 18, 0, 4, 9, 3'b000, 1'b0, 60, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (pl != 36 || bp != 0 || bc != 0 || dn != 1 || er != 0) begin
      n_fail++;
      $display("FAIL small_lane_clear actual plots=%0d badpos=%0d badcol=%0d done=%0d err=%0d required 36/0/0/1/0",
               pl, bp, bc, dn, er);
    end
    // erase on the default instance
    push(0, 0, 0, 2'b01, 3'b110);
    collect(0, 0, 0, 40, 30, 3'b000, 1'b0, 1300, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (pl != 1200 || bp != 0 || bc != 0 || dn != 1) begin
      n_fail++;
      $display("FAIL erase actual plots=%0d badpos=%0d badcol=%0d done=%0d required 1200/0/0/1", pl, bp, bc, dn);
    end
  endtask

  task automatic test_lane_clear();
    int pl, bp, bc, dn, er, fp;
    logic [2:0] a, b;
    push(0, 3, 1, 2'b11, 3'b101);
    collect(0, 120, 0, 40, 120, 3'b000, 1'b0, 4900, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (pl != 4800 || bp != 0 || bc != 0) begin
      n_fail++; $display("FAIL lane_clear actual plots=%0d badpos=%0d badcol=%0d required 4800/0/0", pl, bp, bc);
    end
    n_cmp++;
    if (dn != 1 || er != 0) begin
      n_fail++; $display("FAIL lane_clear_done actual done=%0d err=%0d required 1/0", dn, er);
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    int cyc = 0;
    push(0, 1, 1, 2'b00, 3'b011);
    push(0, 2, 2, 2'b00, 3'b010);
    push(0, 3, 3, 2'b10, 3'b001);
    push(0, 0, 1, 2'b00, 3'b100);
    while (n < 100 && cyc < 500) begin
      @(negedge clk);
      if (plot) n++;
      cyc++;
    end
    n_cmp++;
    if (n != 100) begin n_fail++; $display("FAIL abort_pre_plots actual=%0d required=100", n); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (plot !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || x !== 8'd0 || y !== 7'd0) begin
      n_fail++;
      $display("FAIL abort_immediate actual plot=%b busy=%b ready=%b x=%0d y=%0d required 0/0/0/0/0",
               plot, busy, req_ready, x, y);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready actual=%b required=1", req_ready); end
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (plot || done) n++;
    end
    n_cmp++;
    if (n != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet actual activity=%0d busy=%b required 0/0", n, busy);
    end
  endtask

  task automatic test_invert_border();
    int pl, bp, bc, dn, er, fp;
    logic [2:0] a, b;
    push(0, 0, 0, 2'b10, 3'b101);
    collect(0, 0, 0, 40, 30, 3'b010, c_BORD, 1300, pl, bp, bc, dn, er, fp, a, b);
    n_cmp++;
    if (a !== (c_BORD ? 3'b111 : 3'b010)) begin
      n_fail++; $display("FAIL invert_corner actual=%b required=%b", a, c_BORD ? 3'b111 : 3'b010);
    end
    n_cmp++;
    if (b !== 3'b010) begin n_fail++; $display("FAIL invert_inner actual=%b required=010", b); end
    n_cmp++;
    if (pl != 1200 || bp != 0 || bc != 0 || dn != 1) begin
      n_fail++;
      $display("FAIL invert_tile actual plots=%0d badpos=%0d badcol=%0d done=%0d required 1200/0/0/1", pl, bp, bc, dn);
    end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_back_to_back();
    test_reject();
    test_lane_clear();
    test_reset_abort();
    test_invert_border();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
